// File: rtl/piso_serializer_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and
// the bit-counter width helper (CNT_W = $clog2(WIDTH)).
package piso_pkg;

    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_t;

    localparam int PISO_DEF_WIDTH = 8;

    // Counter width for a given word width; at least one bit.
    function automatic int piso_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Producer handshake plus serial output bundle of piso_serializer.
// Ports: in_data/in_valid/in_ready (word side), ser_out/ser_active/word_done.
interface piso_serializer_if #(
    parameter int WIDTH = piso_pkg::PISO_DEF_WIDTH
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_active;
    logic             word_done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_active,
        input  word_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_active,
        output word_done
    );

endinterface

// File: rtl/piso_hold_buf.sv
// One-entry holding register that lets the next word wait during a shift.
// Ports: clk, rst_n, wr_en/wr_data (fill), rd_en/rd_data (drain), full.
module piso_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en) begin
                data_q <= wr_data;
                full_q <= 1'b1;
            end else if (rd_en) begin
                full_q <= 1'b0;
            end
        end
    end

    assign rd_data = data_q;
    assign full    = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a WIDTH-deep SIPO, one bit per clk.
// Ports: clk, rst_n, bus (slave: in_data/in_valid/in_ready, ser_out/ser_active/word_done).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_serializer_if.slave bus
);

    localparam int CNT_W = piso_cnt_w(WIDTH);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             hold_wr;
    logic             hold_rd;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;

    logic             accept;
    logic             last_bit;

    // Registered ready: no combinational path from in_valid.
    assign accept   = bus.in_valid & ~hold_full;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        if (MSB_FIRST != 0) return {s[WIDTH-2:0], 1'b0};
        else                return {1'b0, s[WIDTH-1:1]};
    endfunction

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (hold_wr),
        .wr_data(bus.in_data),
        .rd_en  (hold_rd),
        .rd_data(hold_data),
        .full   (hold_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PISO_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hold_wr = 1'b0;
        hold_rd = 1'b0;
        case (state_q)
            PISO_IDLE: begin
                if (accept) begin
                    sreg_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = PISO_SHIFT;
                end
            end
            PISO_SHIFT: begin
                sreg_d = shift_once(sreg_q);
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // Word boundary: reload from hold, else bypass, else idle.
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (hold_full) begin
                        sreg_d  = hold_data;
                        hold_rd = 1'b1;
                    end else if (accept) begin
                        sreg_d = bus.in_data;
                    end else begin
                        state_d = PISO_IDLE;
                    end
                end else if (accept) begin
                    hold_wr = 1'b1;
                end
            end
        endcase
    end

    assign bus.in_ready   = ~hold_full;
    assign bus.ser_active = (state_q == PISO_SHIFT);
    assign bus.ser_out    = (state_q == PISO_SHIFT) &
                            ((MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign bus.word_done  = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: two serializers (MSB-first, LSB-first) each feeding a SIPO.
// SIPO contents are compared against the sent word on every word_done.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) ifa ();
    piso_serializer_if #(.WIDTH(8)) ifb ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb)
    );

    // Downstream SIPOs: MSB-first shifts left, LSB-first shifts right.
    logic [7:0] qa, qb;
    always_ff @(posedge clk) begin
        qa <= {qa[6:0], ifa.ser_out};
        qb <= {ifb.ser_out, qb[7:1]};
    end

    task automatic test_reset();
        rst_n        = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_data  = 8'h00;
        ifb.in_valid = 1'b0;
        ifb.in_data  = 8'h00;
        #12;
        checks++;
        if ({ifa.ser_out, ifa.ser_active, ifa.word_done, ifa.in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_a_during: got %b want 0001",
                     {ifa.ser_out, ifa.ser_active, ifa.word_done, ifa.in_ready});
        end
        checks++;
        if ({ifb.ser_out, ifb.ser_active, ifb.word_done, ifb.in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_b_during: got %b want 0001",
                     {ifb.ser_out, ifb.ser_active, ifb.word_done, ifb.in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifa.ser_out, ifa.ser_active, ifa.word_done, ifa.in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_a_after: got %b want 0001",
                     {ifa.ser_out, ifa.ser_active, ifa.word_done, ifa.in_ready});
        end
        @(posedge clk);
        #1;
    endtask

    // Streams n words into dut_a holding in_valid; late=1 presents each
    // following word only on the previous word's last-bit cycle.
    task automatic run_stream(input string name, input int n,
                              input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input bit late);
        logic [7:0] w [3];
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    bit   got;
                    logic r;
                    if (late && k > 0) begin
                        ifa.in_valid = 1'b0;
                        repeat (7) @(posedge clk);
                        #1;
                    end
                    ifa.in_data  = w[k];
                    ifa.in_valid = 1'b1;
                    got = 1'b0;
                    for (int t = 0; t < 64 && !got; t++) begin
                        @(negedge clk);
                        r = ifa.in_ready;
                        @(posedge clk);
                        got = (r === 1'b1);
                    end
                    #1;
                    checks++;
                    if (!got) begin
                        failures++;
                        $display("FAIL %s_accept: word %0d not accepted, want accept within 64 cycles",
                                 name, k);
                    end
                end
                ifa.in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                for (int i = 1; i <= 8 * n + 1; i++) begin
                    int   k;
                    int   b;
                    logic eo, ea, ed, er;
                    k  = (i - 1) / 8;
                    b  = (i - 1) % 8;
                    eo = (i <= 8 * n) ? w[k][7-b] : 1'b0;
                    ea = (i <= 8 * n);
                    ed = (i > 1) && (b == 0);
                    er = late ? 1'b1 : !((i >= 2) && (i <= 8 * (n - 1)) && (b != 0));
                    @(negedge clk);
                    checks++;
                    if ({ifa.ser_out, ifa.ser_active, ifa.word_done, ifa.in_ready}
                        !== {eo, ea, ed, er}) begin
                        failures++;
                        $display("FAIL %s_cyc%0d: out/act/done/rdy got %b want %b", name, i,
                                 {ifa.ser_out, ifa.ser_active, ifa.word_done, ifa.in_ready},
                                 {eo, ea, ed, er});
                    end
                    if (ed) begin
                        checks++;
                        if (qa !== w[k-1]) begin
                            failures++;
                            $display("FAIL %s_q%0d: sipo q got %h want %h", name, k - 1, qa, w[k-1]);
                        end
                    end
                end
            end
        join
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        run_stream("single", 1, 8'hA5, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_stream("b2b", 2, 8'h3C, 8'hC3, 8'h00, 1'b0);
    endtask

    task automatic test_hold_full();
        run_stream("holdfull", 3, 8'h3C, 8'hC3, 8'hFF, 1'b0);
    endtask

    task automatic test_bypass();
        run_stream("bypass", 2, 8'h96, 8'h5A, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w = 8'h81;
        ifa.in_data  = w;
        ifa.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ifa.ser_out, ifa.ser_active} !== {w[7-i], 1'b1}) begin
                failures++;
                $display("FAIL midrst_bit%0d: out/act got %b want %b", i,
                         {ifa.ser_out, ifa.ser_active}, {w[7-i], 1'b1});
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.ser_out, ifa.ser_active, ifa.word_done, ifa.in_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_async: got %b want 0001",
                     {ifa.ser_out, ifa.ser_active, ifa.word_done, ifa.in_ready});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({ifa.ser_active, ifa.word_done} !== 2'b00) begin
                failures++;
                $display("FAIL midrst_idle%0d: act/done got %b want 00", i,
                         {ifa.ser_active, ifa.word_done});
            end
        end
        @(posedge clk);
        #1;
        run_stream("postrst", 1, 8'h42, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'h01;
        ifb.in_data  = w;
        ifb.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic eo, ea, ed;
            eo = (i < 8) ? w[i] : 1'b0;
            ea = (i < 8);
            ed = (i == 8);
            @(negedge clk);
            checks++;
            if ({ifb.ser_out, ifb.ser_active, ifb.word_done} !== {eo, ea, ed}) begin
                failures++;
                $display("FAIL lsb_cyc%0d: out/act/done got %b want %b", i + 1,
                         {ifb.ser_out, ifb.ser_active, ifb.word_done}, {eo, ea, ed});
            end
        end
        checks++;
        if (qb !== w) begin
            failures++;
            $display("FAIL lsb_q: sipo q got %h want %h", qb, w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_full();
        test_reset_mid_word();
        test_lsb_first();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
